// File: rtl/rf32x80_pkg.sv
// Shared sizes and FSM state encoding for the 32x80 register-file access controller.
package rf32x80_pkg;

  localparam int unsigned DEPTH  = 32;
  localparam int unsigned ADR_W  = 5;
  localparam int unsigned DATA_W = 80;

  typedef enum logic {
    SCRUB = 1'b0,
    ARB   = 1'b1
  } state_e;

endpackage

// File: rtl/rf32x80_access_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, priority flips to the loser on update.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       upd_en,
  output logic [1:0] gnt
);

  logic prio_b_q, prio_b_d;

  always_comb begin
    gnt = req;
    if (&req) begin
      gnt = prio_b_q ? 2'b10 : 2'b01;
    end
  end

  // Whoever was just granted loses the next tie.
  always_comb begin
    prio_b_d = prio_b_q;
    if (upd_en && (|gnt)) begin
      prio_b_d = gnt[0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_b_q <= 1'b0;
    end else begin
      prio_b_q <= prio_b_d;
    end
  end

endmodule

// File: rtl/rf32x80_access_ctrl.sv
// Access controller for a 32x80 register file: full clear after reset or on request,
// then round-robin arbitration of two requesters doing masked writes and reads.
module rf32x80_access_ctrl
  import rf32x80_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADR_W-1:0]  a_adr,
  input  logic [DATA_W-1:0] a_mask,
  input  logic [DATA_W-1:0] a_din,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADR_W-1:0]  b_adr,
  input  logic [DATA_W-1:0] b_mask,
  input  logic [DATA_W-1:0] b_din,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_rvld,
  output logic              b_rvld,
  output logic [DATA_W-1:0] rdata,
  input  logic              scrub_req,
  output logic              busy,
  output logic              rf_wr_vld,
  output logic [ADR_W-1:0]  rf_wr_adr,
  output logic [ADR_W-1:0]  rf_rd_adr,
  output logic [DATA_W-1:0] rf_wr_mask,
  output logic [DATA_W-1:0] rf_din,
  input  logic [DATA_W-1:0] rf_rd_data
);

  state_e            state_q, state_d;
  logic [ADR_W-1:0]  cnt_q, cnt_d;
  logic              a_rvld_q, a_rvld_d;
  logic              b_rvld_q, b_rvld_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              arb_en_c;
  logic [1:0]        req_c;
  logic [1:0]        gnt_c;
  logic              win_we_c;
  logic [ADR_W-1:0]  win_adr_c;
  logic [DATA_W-1:0] win_mask_c;
  logic [DATA_W-1:0] win_din_c;
  logic              win_rd_c;

  // A scrub request pre-empts arbitration in the cycle it is seen.
  assign arb_en_c = (state_q == ARB) && !scrub_req && !reset;
  assign req_c    = {b_req, a_req} & {2{arb_en_c}};

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .reset  (reset),
    .req    (req_c),
    .upd_en (arb_en_c),
    .gnt    (gnt_c)
  );

  always_comb begin
    win_we_c   = a_we;
    win_adr_c  = a_adr;
    win_mask_c = a_mask;
    win_din_c  = a_din;
    if (gnt_c[1]) begin
      win_we_c   = b_we;
      win_adr_c  = b_adr;
      win_mask_c = b_mask;
      win_din_c  = b_din;
    end
  end

  assign win_rd_c = (|gnt_c) && !win_we_c;

  always_comb begin
    rf_wr_vld  = 1'b0;
    rf_wr_adr  = win_adr_c;
    rf_wr_mask = win_mask_c;
    rf_din     = win_din_c;
    if (state_q == SCRUB) begin
      rf_wr_vld  = !reset;
      rf_wr_adr  = cnt_q;
      rf_wr_mask = {DATA_W{1'b1}};
      rf_din     = '0;
    end else if ((|gnt_c) && win_we_c) begin
      rf_wr_vld  = 1'b1;
    end
  end

  assign rf_rd_adr = win_adr_c;
  assign a_gnt     = gnt_c[0];
  assign b_gnt     = gnt_c[1];
  assign busy      = (state_q == SCRUB);
  assign a_rvld    = a_rvld_q;
  assign b_rvld    = b_rvld_q;
  assign rdata     = rdata_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_rvld_d = gnt_c[0] && !a_we;
    b_rvld_d = gnt_c[1] && !b_we;
    rdata_d  = win_rd_c ? rf_rd_data : rdata_q;
    case (state_q)
      SCRUB: begin
        cnt_d = cnt_q + ADR_W'(1);
        if (cnt_q == ADR_W'(DEPTH - 1)) begin
          state_d = ARB;
          cnt_d   = '0;
        end
      end
      ARB: begin
        if (scrub_req) begin
          state_d = SCRUB;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = SCRUB;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= SCRUB;
      cnt_q    <= '0;
      a_rvld_q <= 1'b0;
      b_rvld_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_rvld_q <= a_rvld_d;
      b_rvld_q <= b_rvld_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_rf32x80_access_ctrl.sv
// Self-checking bench for rf32x80_access_ctrl: behavioural register file, reference model,
// directed vector table, hand-written scrub/reset sequences and randomized traffic.
module tb_rf32x80_access_ctrl;

  localparam logic [79:0] ONES   = {80{1'b1}};
  localparam logic [79:0] M_FF00 = 80'hFF00;
  localparam logic [79:0] D_1234 = 80'h1234;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we, scrub_req;
  logic [4:0]  a_adr, b_adr;
  logic [79:0] a_mask, a_din, b_mask, b_din;
  logic        a_gnt, b_gnt, a_rvld, b_rvld, busy, rf_wr_vld;
  logic [79:0] rdata, rf_wr_mask, rf_din, rf_rd_data;
  logic [4:0]  rf_wr_adr, rf_rd_adr;

  logic [79:0] rf_mem [32];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int          scrub_left;
  bit          next_a;
  bit          m_ar, m_br;
  logic [79:0] m_rdata;
  logic [79:0] ref_mem [32];

  typedef struct {
    logic        a_req, a_we;
    logic [4:0]  a_adr;
    logic [79:0] a_mask, a_din;
    logic        b_req, b_we;
    logic [4:0]  b_adr;
    logic [79:0] b_mask, b_din;
    logic        e_ag, e_bg, e_ar, e_br;
    logic [79:0] e_rdata;
  } vec_t;

  vec_t tbl [11];

  rf32x80_access_ctrl dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_adr(a_adr), .a_mask(a_mask), .a_din(a_din),
    .b_req(b_req), .b_we(b_we), .b_adr(b_adr), .b_mask(b_mask), .b_din(b_din),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvld(a_rvld), .b_rvld(b_rvld), .rdata(rdata),
    .scrub_req(scrub_req), .busy(busy),
    .rf_wr_vld(rf_wr_vld), .rf_wr_adr(rf_wr_adr), .rf_rd_adr(rf_rd_adr),
    .rf_wr_mask(rf_wr_mask), .rf_din(rf_din), .rf_rd_data(rf_rd_data)
  );

  always #5 clk = ~clk;

  // Behavioural 32x80 register file: masked synchronous write, asynchronous read.
  always @(posedge clk) begin
    if (rf_wr_vld) begin
      rf_mem[rf_wr_adr] <= (rf_mem[rf_wr_adr] & ~rf_wr_mask) | (rf_din & rf_wr_mask);
    end
  end
  assign rf_rd_data = rf_mem[rf_rd_adr];

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    scrub_left = 32;
    next_a     = 1'b1;
    m_ar       = 1'b0;
    m_br       = 1'b0;
    m_rdata    = '0;
  endtask

  task automatic set_in(input logic ar, aw, input logic [4:0] aa, input logic [79:0] am, ad,
                        input logic br, bw, input logic [4:0] ba, input logic [79:0] bm, bd,
                        input logic sc);
    a_req = ar; a_we = aw; a_adr = aa; a_mask = am; a_din = ad;
    b_req = br; b_we = bw; b_adr = ba; b_mask = bm; b_din = bd;
    scrub_req = sc;
  endtask

  task automatic idle();
    set_in(0, 0, 5'd0, '0, '0, 0, 0, 5'd0, '0, '0, 0);
  endtask

  // One clock cycle: called just after negedge with inputs applied, returns at next negedge.
  task automatic tick();
    bit          ga, gb, wr, rd, scr;
    logic [4:0]  adr;
    logic [79:0] msk, dat;
    #1;
    ga = 0; gb = 0;
    scr = (scrub_left > 0);
    if (!scr && !scrub_req) begin
      if (a_req && (!b_req || next_a)) ga = 1;
      else if (b_req) gb = 1;
    end
    wr  = (ga && a_we) || (gb && b_we);
    rd  = (ga && !a_we) || (gb && !b_we);
    adr = gb ? b_adr : a_adr;
    msk = gb ? b_mask : a_mask;
    dat = gb ? b_din : a_din;
    chk("a_gnt", 80'(a_gnt), 80'(ga));
    chk("b_gnt", 80'(b_gnt), 80'(gb));
    chk("gnt_onehot", 80'(a_gnt & b_gnt), 80'(0));
    chk("busy", 80'(busy), 80'(scr));
    chk("rf_wr_vld", 80'(rf_wr_vld), 80'(scr || wr));
    if (scr) begin
      chk("scrub_adr", 80'(rf_wr_adr), 80'(32 - scrub_left));
      chk("scrub_mask", rf_wr_mask, ONES);
      chk("scrub_din", rf_din, '0);
    end else if (wr) begin
      chk("wr_adr", 80'(rf_wr_adr), 80'(adr));
      chk("wr_mask", rf_wr_mask, msk);
      chk("wr_din", rf_din, dat);
    end else if (rd) begin
      chk("rd_adr", 80'(rf_rd_adr), 80'(adr));
    end
    chk("a_rvld", 80'(a_rvld), 80'(m_ar));
    chk("b_rvld", 80'(b_rvld), 80'(m_br));
    chk("rdata", rdata, m_rdata);
    @(posedge clk);
    m_ar = ga && !a_we;
    m_br = gb && !b_we;
    if (rd) m_rdata = ref_mem[adr];
    if (scr) begin
      ref_mem[32 - scrub_left] = '0;
      scrub_left--;
    end else if (scrub_req) begin
      scrub_left = 32;
    end else if (wr) begin
      ref_mem[adr] = (ref_mem[adr] & ~msk) | (dat & msk);
    end
    if (ga) next_a = 1'b0;
    if (gb) next_a = 1'b1;
    @(negedge clk);
  endtask

  task automatic rand_in(input int scrub_pct);
    set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           80'({$urandom(), $urandom(), $urandom()}), 80'({$urandom(), $urandom(), $urandom()}),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           80'({$urandom(), $urandom(), $urandom()}), 80'({$urandom(), $urandom(), $urandom()}),
           1'($urandom_range(0, 99) < scrub_pct));
  endtask

  function automatic vec_t mk(input logic ar, aw, input logic [4:0] aa, input logic [79:0] am, ad,
                              input logic br, bw, input logic [4:0] ba, input logic [79:0] bm, bd,
                              input logic eag, ebg, ear, ebr, input logic [79:0] erd);
    vec_t v;
    v.a_req = ar; v.a_we = aw; v.a_adr = aa; v.a_mask = am; v.a_din = ad;
    v.b_req = br; v.b_we = bw; v.b_adr = ba; v.b_mask = bm; v.b_din = bd;
    v.e_ag = eag; v.e_bg = ebg; v.e_ar = ear; v.e_br = ebr; v.e_rdata = erd;
    return v;
  endfunction

  initial begin
    int first;
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;

    tbl[0]  = mk(1, 1, 5'd5, M_FF00, ONES,   0, 0, 5'd0, '0,   '0,     1, 0, 1, 0, '0);
    tbl[1]  = mk(1, 0, 5'd5, '0,     '0,     0, 0, 5'd0, '0,   '0,     1, 0, 0, 0, '0);
    tbl[2]  = mk(0, 0, 5'd0, '0,     '0,     1, 1, 5'd3, ONES, D_1234, 0, 1, 1, 0, M_FF00);
    tbl[3]  = mk(1, 0, 5'd5, '0,     '0,     1, 0, 5'd3, '0,   '0,     1, 0, 0, 0, M_FF00);
    tbl[4]  = mk(1, 0, 5'd5, '0,     '0,     1, 0, 5'd3, '0,   '0,     0, 1, 1, 0, M_FF00);
    tbl[5]  = mk(1, 0, 5'd5, '0,     '0,     1, 0, 5'd3, '0,   '0,     1, 0, 0, 1, D_1234);
    tbl[6]  = mk(1, 0, 5'd5, '0,     '0,     1, 0, 5'd3, '0,   '0,     0, 1, 1, 0, M_FF00);
    tbl[7]  = mk(1, 1, 5'd3, '0,     ONES,   0, 0, 5'd0, '0,   '0,     1, 0, 0, 1, D_1234);
    tbl[8]  = mk(1, 0, 5'd3, '0,     '0,     0, 0, 5'd0, '0,   '0,     1, 0, 0, 0, D_1234);
    tbl[9]  = mk(0, 0, 5'd0, '0,     '0,     1, 1, 5'd7, ONES, ONES,   0, 1, 1, 0, D_1234);
    tbl[10] = mk(1, 0, 5'd7, '0,     '0,     0, 0, 5'd0, '0,   '0,     1, 0, 0, 0, D_1234);

    // Reset state, with requests asserted
    reset = 1'b1;
    set_in(1, 1, 5'd1, ONES, ONES, 1, 1, 5'd2, ONES, ONES, 0);
    #1;
    chk("rst_busy", 80'(busy), 80'(1));
    chk("rst_wr_vld", 80'(rf_wr_vld), 80'(0));
    chk("rst_a_gnt", 80'(a_gnt), 80'(0));
    chk("rst_b_gnt", 80'(b_gnt), 80'(0));
    chk("rst_a_rvld", 80'(a_rvld), 80'(0));
    chk("rst_b_rvld", 80'(b_rvld), 80'(0));
    chk("rst_rdata", rdata, '0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold_wr_vld", 80'(rf_wr_vld), 80'(0));
    reset = 1'b0;
    model_reset();

    // Scrub of 32 entries, first grant in cycle 33 with a_req held
    first = 0;
    for (int c = 1; c <= 33; c++) begin
      set_in(1, 0, 5'd0, '0, '0, 0, 0, 5'd0, '0, '0, 0);
      #1;
      if (a_gnt && first == 0) first = c;
      tick();
    end
    chk("first_a_gnt_cycle", 80'(first), 80'(33));

    // Directed vector table
    for (int i = 0; i < 11; i++) begin
      set_in(tbl[i].a_req, tbl[i].a_we, tbl[i].a_adr, tbl[i].a_mask, tbl[i].a_din,
             tbl[i].b_req, tbl[i].b_we, tbl[i].b_adr, tbl[i].b_mask, tbl[i].b_din, 0);
      #1;
      chk($sformatf("tbl%0d_a_gnt", i), 80'(a_gnt), 80'(tbl[i].e_ag));
      chk($sformatf("tbl%0d_b_gnt", i), 80'(b_gnt), 80'(tbl[i].e_bg));
      chk($sformatf("tbl%0d_a_rvld", i), 80'(a_rvld), 80'(tbl[i].e_ar));
      chk($sformatf("tbl%0d_b_rvld", i), 80'(b_rvld), 80'(tbl[i].e_br));
      chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].e_rdata);
      tick();
    end

    // Scrub request alongside a B read: no grant, owed A read still completes
    set_in(0, 0, 5'd0, '0, '0, 1, 0, 5'd7, '0, '0, 1);
    #1;
    chk("scrq_b_gnt", 80'(b_gnt), 80'(0));
    chk("scrq_wr_vld", 80'(rf_wr_vld), 80'(0));
    chk("scrq_owed_a_rvld", 80'(a_rvld), 80'(1));
    chk("scrq_owed_rdata", rdata, ONES);
    tick();
    chk("scrq_busy_next", 80'(busy), 80'(1));
    for (int c = 0; c < 32; c++) begin
      rand_in(0);
      if (c == 10) scrub_req = 1'b1;
      tick();
    end
    set_in(0, 0, 5'd0, '0, '0, 1, 0, 5'd7, '0, '0, 0);
    tick();
    idle();
    #1;
    chk("scrubbed_b_rvld", 80'(b_rvld), 80'(1));
    chk("scrubbed_rdata7", rdata, '0);
    tick();

    // Reset at scrub entry 12 restarts the scrub from entry 0
    set_in(1, 1, 5'd9, ONES, 80'hABCD, 0, 0, 5'd0, '0, '0, 0);
    tick();
    set_in(1, 0, 5'd9, '0, '0, 0, 0, 5'd0, '0, '0, 0);
    tick();
    idle();
    scrub_req = 1'b1;
    tick();
    idle();
    for (int c = 0; c < 12; c++) tick();
    #1;
    chk("pre_rst_scrub_adr", 80'(rf_wr_adr), 80'(12));
    chk("pre_rst_rdata", rdata, 80'hABCD);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 80'(busy), 80'(1));
    chk("midrst_wr_vld", 80'(rf_wr_vld), 80'(0));
    chk("midrst_rdata", rdata, '0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    idle();
    #1;
    chk("restart_adr0", 80'(rf_wr_adr), 80'(0));
    for (int c = 0; c < 32; c++) tick();
    #1;
    chk("restart_done_busy", 80'(busy), 80'(0));

    // Randomized traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      rand_in(2);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
